// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a one-byte holding buffer, so frames can run back-to-back.
// The outputs are registered from the current FSM state, so the line lags the state by one cycle.
module uart_transmit #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int TMR_LENGTH   = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       uart_rx,
  output logic       transmitting,
  output logic       tx_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [TMR_LENGTH-1:0] TMR_LAST = TMR_LENGTH'(CLKS_PER_BIT - 1);

  state_t                state_reg, state_next;
  logic [TMR_LENGTH-1:0] timer_reg, timer_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic [7:0]            shift_reg, shift_next;
  logic [7:0]            buffer_reg, buffer_next;
  logic                  buffer_full_reg, buffer_full_next;
  logic                  uart_rx_next, ready_next, transmitting_next, tx_done_next;
  logic                  bit_done;

  assign bit_done = (timer_reg == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      buffer_reg      <= '0;
      buffer_full_reg <= 1'b0;
      uart_rx         <= 1'b1;
      ready           <= 1'b1;
      transmitting    <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      buffer_reg      <= buffer_next;
      buffer_full_reg <= buffer_full_next;
      uart_rx         <= uart_rx_next;
      ready           <= ready_next;
      transmitting    <= transmitting_next;
      tx_done         <= tx_done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = '0;
    bit_idx_next     = bit_idx_reg;
    shift_next       = shift_reg;
    buffer_next      = buffer_reg;
    buffer_full_next = buffer_full_reg;

    if (state_reg != IDLE) begin
      timer_next = bit_done ? '0 : timer_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (buffer_full_reg) begin
          shift_next       = buffer_reg;
          buffer_full_next = 1'b0;
          bit_idx_next     = '0;
          state_next       = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          // A waiting byte starts its frame immediately, with no idle bit between.
          if (buffer_full_reg) begin
            shift_next       = buffer_reg;
            buffer_full_next = 1'b0;
            bit_idx_next     = '0;
            state_next       = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // ready is low whenever the buffer is full, so this never collides with a drain.
    if (send && ready) begin
      buffer_next      = data;
      buffer_full_next = 1'b1;
    end
  end

  always_comb begin
    uart_rx_next = 1'b1;
    case (state_reg)
      START:   uart_rx_next = 1'b0;
      DATA:    uart_rx_next = shift_reg[0];
      default: uart_rx_next = 1'b1;
    endcase
    transmitting_next = (state_reg != IDLE);
    tx_done_next      = (state_reg == STOP) && bit_done;
    ready_next        = !buffer_full_next;
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Scoreboarded bench for uart_transmit: accepted bytes are queued, and a line monitor
// captures each 10-bit frame and compares it with the frame built from the queued byte.
module tb_uart_transmit;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       send;
  logic       ready;
  logic       uart_rx;
  logic       transmitting;
  logic       tx_done;

  uart_transmit #(.CLKS_PER_BIT(CPB), .TMR_LENGTH(14)) dut (
    .clk(clk), .rst(rst), .data(data), .send(send),
    .ready(ready), .uart_rx(uart_rx), .transmitting(transmitting), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         acc_edge;
    bit         lat;
    bit         gap;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    failures = 0;
  int    ncyc = 0;
  bit    in_frame = 0;
  int    idx = 0;
  int    frame_start = 0;
  int    prev_start = -1000;
  int    frames_seen = 0;
  int    expected_frames = 0;
  bit    lat_flag = 0;
  bit    gap_flag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line monitor and scoreboard
  initial begin
    logic [FRAME-1:0] line_v;
    logic [FRAME-1:0] done_v;
    logic [FRAME-1:0] exp_line;
    logic [FRAME-1:0] exp_done;
    logic [9:0]       fb;
    bit               trans_ok;
    item_t            it;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        in_frame = 0;
        q.delete();
      end else begin
        if (send && ready) begin
          it.b = data; it.acc_edge = ncyc + 1; it.lat = lat_flag; it.gap = gap_flag;
          q.push_back(it);
          $display("accept byte=%02h edge=%0d", data, ncyc + 1);
        end
        if (!in_frame && uart_rx == 1'b0) begin
          in_frame = 1; idx = 0; frame_start = ncyc; trans_ok = 1;
        end
        if (in_frame) begin
          line_v[idx] = uart_rx;
          done_v[idx] = tx_done;
          if (transmitting !== 1'b1) trans_ok = 0;
          idx++;
          if (idx == FRAME) begin
            in_frame = 0;
            frames_seen++;
            if (q.size() == 0) begin
              chk("unexpected_frame", {24'd0, line_v}, 64'd0);
            end else begin
              it = q.pop_front();
              fb = {1'b1, it.b, 1'b0};
              for (int k = 0; k < FRAME; k++) begin
                exp_line[k] = fb[k / CPB];
                exp_done[k] = (k == FRAME - 1);
              end
              $display("frame start=%0d byte=%02h line=%010h", frame_start, it.b, line_v);
              chk("frame_line", {24'd0, line_v}, {24'd0, exp_line});
              chk("tx_done_pulse", {24'd0, done_v}, {24'd0, exp_done});
              chk("transmitting_high", {63'd0, trans_ok}, 64'd1);
              if (it.lat) chk("start_latency", 64'(frame_start - it.acc_edge), 64'd2);
              if (it.gap) chk("no_gap", 64'(frame_start - prev_start), 64'(FRAME));
            end
            prev_start = frame_start;
          end
        end else begin
          chk("idle_outputs", {62'd0, tx_done, transmitting}, 64'd0);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit hold, input bit lat, input bit gap);
    bit got;
    got = 0;
    @(posedge clk); #1;
    data = b; send = 1'b1; lat_flag = lat; gap_flag = gap;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (!hold) send = 1'b0;
    data = 8'($urandom);
    lat_flag = 0; gap_flag = 0;
    expected_frames++;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && !in_frame) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit hit;
    rst = 1'b0; send = 1'b0; data = 8'h00;
    #3 rst = 1'b1;
    #1;
    chk("reset_uart_rx", {63'd0, uart_rx}, 64'd1);
    chk("reset_ready", {63'd0, ready}, 64'd1);
    chk("reset_transmitting", {63'd0, transmitting}, 64'd0);
    chk("reset_tx_done", {63'd0, tx_done}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single byte from idle
    send_byte(8'h55, 0, 1, 0);
    wait_idle();

    // Back-to-back
    send_byte(8'hA3, 0, 1, 0);
    send_byte(8'h0F, 0, 0, 1);
    wait_idle();

    // Overrun with send held high
    send_byte(8'h11, 1, 1, 0);
    send_byte(8'h22, 1, 0, 1);
    send_byte(8'h33, 0, 0, 1);
    wait_idle();

    // Data changes every cycle after the accept
    send_byte(8'hC6, 0, 1, 0);
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1 data = 8'($urandom);
    end
    wait_idle();

    // Reset during data bit 3 with a second byte buffered
    send_byte(8'hFF, 0, 1, 0);
    send_byte(8'h5A, 0, 0, 0);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (in_frame && idx == 18) begin hit = 1; break; end
    end
    chk("reached_bit3", {63'd0, hit}, 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midreset_uart_rx", {63'd0, uart_rx}, 64'd1);
    chk("midreset_ready", {63'd0, ready}, 64'd1);
    chk("midreset_transmitting", {63'd0, transmitting}, 64'd0);
    chk("midreset_tx_done", {63'd0, tx_done}, 64'd0);
    expected_frames -= 2;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; data = 8'h80; send = 1'b1; lat_flag = 1;
    @(negedge clk);
    chk("post_reset_ready", {63'd0, ready}, 64'd1);
    @(posedge clk); #1;
    send = 1'b0; lat_flag = 0; data = 8'($urandom);
    expected_frames++;
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      send_byte(8'($urandom), 0, 0, 0);
    end
    wait_idle();

    chk("frame_count", 64'(frames_seen), 64'(expected_frames));
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
